// File: rtl/sonic_upstream_gearbox.sv
// Receive-side 40->64 gearbox: packs eight 40-bit PHY words into five 64-bit FIFO words.
// Output strobe wrreq pulses 5 of 8 cycles; overflow is sticky when a word is lost to full.
module sonic_upstream_gearbox #(
  parameter int INPUT_WIDTH  = 40,
  parameter int OUTPUT_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic [INPUT_WIDTH-1:0]  data_in,
  input  logic                    full,
  output logic                    wrreq,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    overflow
);

  if (INPUT_WIDTH != 40 || OUTPUT_WIDTH != 64) begin : g_bad_width
    $error("sonic_upstream_gearbox supports only INPUT_WIDTH=40, OUTPUT_WIDTH=64");
  end

  localparam int BUF_W  = 96;
  localparam int FILL_W = 7;

  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7
  } state_e;

  state_e                  state_q, state_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    wrreq_q, wrreq_d;
  logic [OUTPUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                    overflow_q, overflow_d;

  logic [BUF_W-1:0]        appended;
  logic [FILL_W-1:0]       fill_sum;

  function automatic state_e next_state(input state_e s);
    case (s)
      IDLE:    return S1;
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S4;
      S4:      return S5;
      S5:      return S6;
      S6:      return S7;
      default: return S0;
    endcase
  endfunction

  // Sampling in these states pushes the fill to 64 or more.
  function automatic logic emit_slot(input state_e s);
    return (s == S1) || (s == S3) || (s == S4) || (s == S6) || (s == S7);
  endfunction

  // New word lands directly above the residual bits; bit 0 stays earliest in time.
  assign appended = buf_q | (BUF_W'(data_in) << fill_q);
  assign fill_sum = fill_q + FILL_W'(INPUT_WIDTH);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    buf_d      = buf_q;
    fill_d     = fill_q;
    wrreq_d    = 1'b0;
    data_out_d = data_out_q;
    overflow_d = overflow_q;

    if (!ena) begin
      state_d = IDLE;
      buf_d   = '0;
      fill_d  = '0;
    end else begin
      state_d = next_state(state_q);
      if (emit_slot(state_q)) begin
        buf_d  = appended >> OUTPUT_WIDTH;
        fill_d = fill_sum - FILL_W'(OUTPUT_WIDTH);
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          wrreq_d    = 1'b1;
          data_out_d = appended[OUTPUT_WIDTH-1:0];
        end
      end else begin
        buf_d  = appended;
        fill_d = fill_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    if (reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      fill_q     <= '0;
      wrreq_q    <= 1'b0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      wrreq_q    <= wrreq_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign wrreq    = wrreq_q;
  assign data_out = data_out_q;
  assign overflow = overflow_q;

endmodule
